// File: rtl/seg_display_scheduler_pkg.sv
// Shared definitions for the segment display scheduler.
//   NUM_REQ            number of requesters sharing the display
//   WORD_W             width of one display word (8 hex digits)
//   PTR_W              width of the round-robin pointer
//   BLANK_WORD_DEFAULT word shown while nobody owns the display
//   state_e            scheduler FSM states
//   onehot_idx()       index of the set bit of a one-hot requester vector
package seg_display_scheduler_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned PTR_W   = 2;

   localparam logic [WORD_W-1:0] BLANK_WORD_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic {
      StIdle = 1'b0,
      StHold = 1'b1
   } state_e;

   // Zero input yields index 0; callers only use it with a valid winner.
   function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (oh[i]) begin
            idx = PTR_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/seg_display_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin priority selector.
// Ports:
//   req     in  4  request vector, bit i = requester i
//   pointer in  2  index where the priority search starts
//   winner  out 4  one-hot winner, all-zero when req is all-zero
// The search begins at pointer and walks upward modulo 4; the first set
// request bit wins.
module rr_arbiter4
   import seg_display_scheduler_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   pointer,
   output logic [NUM_REQ-1:0] winner
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         // 2-bit add wraps naturally, giving the modulo-4 walk.
         idx = pointer + PTR_W'(k);
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-sliced owner scheduler for a shared 8-digit hex display.
// Requesters compete round-robin; the winner's word is frozen on the display
// for exactly HOLD_CYCLES clocks, after which the scheduler re-arbitrates.
// Parameters:
//   HOLD_CYCLES  clocks each granted word stays up (2 .. 2^32-1)
//   BLANK_WORD   word driven while no requester is granted
// Ports:
//   clk        in  1    system clock, rising edge
//   rst        in  1    synchronous active-high reset
//   req        in  4    per-requester display request
//   data_in    in  128  requester words, requester i at [32*i +: 32]
//   grant      out 4    one-hot display owner, zero when idle
//   ack        out 4    one-cycle pulse when requester i's word is latched
//   disp_word  out 32   word for the downstream 7-segment driver
//   led        out 4    mirror of grant
module seg_display_scheduler
   import seg_display_scheduler_pkg::*;
#(
   parameter int unsigned       HOLD_CYCLES = 50_000_000,
   parameter logic [WORD_W-1:0] BLANK_WORD  = BLANK_WORD_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*WORD_W-1:0] data_in,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        ack,
   output logic [WORD_W-1:0]         disp_word,
   output logic [NUM_REQ-1:0]        led
);

   // Count value on the last cycle of a hold.
   localparam logic [31:0] HoldLast = 32'(HOLD_CYCLES - 1);

   state_e              state_q;
   logic [PTR_W-1:0]    ptr_q;
   logic [31:0]         cnt_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [NUM_REQ-1:0]  ack_q;
   logic [WORD_W-1:0]   word_q;

   logic [NUM_REQ-1:0]  winner;
   logic [PTR_W-1:0]    win_idx;
   logic [WORD_W-1:0]   win_word;
   logic                any_req;

   rr_arbiter4 u_arb (
      .req     (req),
      .pointer (ptr_q),
      .winner  (winner)
   );

   assign any_req  = |req;
   assign win_idx  = onehot_idx(winner);
   assign win_word = data_in[32'(win_idx) * WORD_W +: WORD_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         word_q  <= BLANK_WORD;
      end else begin
         unique case (state_q)
            StIdle: begin
               cnt_q <= '0;
               if (any_req) begin
                  state_q <= StHold;
                  grant_q <= winner;
                  ack_q   <= winner;
                  word_q  <= win_word;
                  ptr_q   <= win_idx + PTR_W'(1);
               end else begin
                  grant_q <= '0;
                  ack_q   <= '0;
                  word_q  <= BLANK_WORD;
               end
            end
            StHold: begin
               if (cnt_q == HoldLast) begin
                  cnt_q <= '0;
                  if (any_req) begin
                     // Hand straight over (or re-grant) with no blank cycle.
                     grant_q <= winner;
                     ack_q   <= winner;
                     word_q  <= win_word;
                     ptr_q   <= win_idx + PTR_W'(1);
                  end else begin
                     state_q <= StIdle;
                     grant_q <= '0;
                     ack_q   <= '0;
                     word_q  <= BLANK_WORD;
                  end
               end else begin
                  // Requests are ignored mid-hold: no preemption, no early release.
                  cnt_q <= cnt_q + 32'd1;
                  ack_q <= '0;
               end
            end
         endcase
      end
   end

   assign grant     = grant_q;
   assign ack       = ack_q;
   assign disp_word = word_q;
   assign led       = grant_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
module tb_seg_display_scheduler;

   localparam int          HOLD  = 4;
   localparam logic [31:0] BLANK = 32'hFFFF_FFFF;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [127:0] data_in;
   logic [3:0]   grant;
   logic [3:0]   ack;
   logic [31:0]  disp_word;
   logic [3:0]   led;

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the display, for how many cycles so far.
   int          m_owner;
   int          m_elapsed;
   int          m_ptr;
   logic [31:0] m_word;
   logic [3:0]  m_ack;

   seg_display_scheduler #(
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data_in   (data_in),
      .grant     (grant),
      .ack       (ack),
      .disp_word (disp_word),
      .led       (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] m_grant();
      return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
   endfunction

   // Apply the scheduling rules for one rising edge, using the inputs present at it.
   task automatic model_edge();
      int w;
      w = -1;
      m_ack = 4'b0000;
      if (rst) begin
         m_owner   = -1;
         m_ptr     = 0;
         m_elapsed = 0;
         m_word    = BLANK;
      end else if (m_owner < 0 || m_elapsed == HOLD) begin
         for (int k = 0; k < 4; k++) begin
            if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
         end
         if (w >= 0) begin
            m_owner   = w;
            m_word    = data_in[w*32 +: 32];
            m_ack     = 4'(1 << w);
            m_elapsed = 1;
            m_ptr     = (w + 1) % 4;
         end else begin
            m_owner   = -1;
            m_word    = BLANK;
            m_elapsed = 0;
         end
      end else begin
         m_elapsed++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("grant", 32'(grant), 32'(m_grant()));
      check("ack", 32'(ack), 32'(m_ack));
      check("disp_word", disp_word, m_word);
      check("led", 32'(led), 32'(m_grant()));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst     = 1'b1;
      req     = 4'b0000;
      data_in = '0;
      m_owner = -1; m_ptr = 0; m_elapsed = 0; m_word = BLANK; m_ack = 4'b0000;

      // Reset for two cycles.
      ticks(2);
      check("rst_disp", disp_word, 32'hFFFF_FFFF);
      check("rst_grant", 32'(grant), 32'h0);

      // Single requester held: re-ack every HOLD cycles.
      rst = 1'b0;
      data_in = {32'h002D0040, 32'h000D001C, 32'h01020304, 32'h0D0E0F10};
      req = 4'b0001;
      tick();
      check("single_grant", 32'(grant), 32'h1);
      check("single_ack", 32'(ack), 32'h1);
      check("single_word", disp_word, 32'h0D0E0F10);
      tick();
      check("single_ack_drop", 32'(ack), 32'h0);
      ticks(3);
      check("single_reack", 32'(ack), 32'h1);
      ticks(4);
      req = 4'b0000;
      ticks(5);
      check("single_idle", disp_word, BLANK);

      // Round-robin over all four from reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         tick();
         check("rr_grant", 32'(grant), 32'(1 << (g % 4)));
         ticks(3);
         check("rr_held", 32'(grant), 32'(1 << (g % 4)));
      end

      // Frozen word and hold not shortened when requester 2 drops.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b0100;
      tick();
      check("frz_grant", 32'(grant), 32'h4);
      req = 4'b0000;
      data_in[64 +: 32] = 32'hDEAD_BEEF;
      ticks(3);
      check("frz_word", disp_word, 32'h000D001C);
      check("frz_grant_held", 32'(grant), 32'h4);
      tick();
      check("frz_blank", disp_word, BLANK);
      check("frz_idle", 32'(grant), 32'h0);

      // Reset in cycle 2 of a grant to requester 3, then 1010 restarts at requester 1.
      req = 4'b1000;
      ticks(2);
      check("mid_grant", 32'(grant), 32'h8);
      rst = 1'b1;
      tick();
      check("mid_rst_grant", 32'(grant), 32'h0);
      check("mid_rst_word", disp_word, BLANK);
      rst = 1'b0;
      req = 4'b1010;
      tick();
      check("post_rst_grant", 32'(grant), 32'h2);
      check("post_rst_ack", 32'(ack), 32'h2);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         req     = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         data_in = {$urandom, $urandom, $urandom, $urandom};
         rst     = ($urandom_range(0, 49) == 0);
         tick();
         check("onehot", 32'($countones(grant) <= 1), 32'h1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
